// File: rtl/pifo_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Holds the arbiter state encoding and the index wrap-increment used for the rotating pointer.
package pifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Explicit wrap so non-power-of-two limits never need a modulo.
    function automatic int wrap_inc(input int idx, input int limit);
        return (idx == limit - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Rotating find-first: lowest set request at or above ptr, else lowest set request overall.
// Purely combinational; the caller registers the result.
module rr_priority_select #(
    parameter int NUM_REQ   = 8,
    parameter int REQ_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [REQ_WIDTH-1:0] i_ptr,
    output logic                 o_found,
    output logic [NUM_REQ-1:0]   o_winner,
    output logic [REQ_WIDTH-1:0] o_winner_id
);

    logic                 w_masked_found;
    logic [REQ_WIDTH-1:0] w_masked_id;
    logic [REQ_WIDTH-1:0] w_unmasked_id;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_masked_found = 1'b0;
        w_masked_id    = '0;
        w_unmasked_id  = '0;
        // Descending scan: the last hit written is the lowest matching index.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_unmasked_id = REQ_WIDTH'(i);
            end
            if (i_req[i] && (i >= int'(i_ptr))) begin
                w_masked_found = 1'b1;
                w_masked_id    = REQ_WIDTH'(i);
            end
        end
    end

    assign o_found     = |i_req;
    assign o_winner_id = w_masked_found ? w_masked_id : w_unmasked_id;
    assign o_winner    = o_found ? (NUM_REQ'(1) << o_winner_id) : '0;

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter granting one requester a burst of up to BURST_LEN accepted beats.
// Release (burst done or request dropped) re-arbitrates in the same cycle from the next index.
module rr_burst_arbiter
    import pifo_arb_pkg::*;
#(
    parameter int NUM_REQ     = 8,
    parameter int REQ_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int BURST_LEN   = 4,
    parameter int BURST_WIDTH = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     i__req,
    input  logic                   i__ready,
    output logic [NUM_REQ-1:0]     o__grant,
    output logic [REQ_WIDTH-1:0]   o__grant_id,
    output logic                   o__valid,
    output logic [BURST_WIDTH-1:0] o__beat_count,
    output logic                   o__last
);

    arb_state_t             r_state;
    logic [REQ_WIDTH-1:0]   r_ptr;
    logic [NUM_REQ-1:0]     r_grant;
    logic [REQ_WIDTH-1:0]   r_grant_id;
    logic [BURST_WIDTH-1:0] r_beat_count;

    arb_state_t             w_state_nxt;
    logic [REQ_WIDTH-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0]     w_grant_nxt;
    logic [REQ_WIDTH-1:0]   w_grant_id_nxt;
    logic [BURST_WIDTH-1:0] w_beat_nxt;

    logic                   w_busy;
    logic                   w_accept;
    logic                   w_release;
    logic [REQ_WIDTH-1:0]   w_ptr_inc;
    logic [REQ_WIDTH-1:0]   w_sel_ptr;
    logic                   w_found;
    logic [NUM_REQ-1:0]     w_winner;
    logic [REQ_WIDTH-1:0]   w_winner_id;

    assign w_busy    = (r_state == ARB_BUSY);
    assign o__valid  = w_busy && i__req[r_grant_id];
    assign o__last   = o__valid && (r_beat_count == BURST_WIDTH'(BURST_LEN - 1));
    assign w_accept  = o__valid && i__ready;
    assign w_release = w_busy && (!i__req[r_grant_id] || (w_accept && o__last));
    assign w_ptr_inc = REQ_WIDTH'(wrap_inc(int'(r_grant_id), NUM_REQ));
    // On release the search already starts after the winner, so it is lowest priority.
    assign w_sel_ptr = w_release ? w_ptr_inc : r_ptr;

    rr_priority_select #(
        .NUM_REQ   (NUM_REQ),
        .REQ_WIDTH (REQ_WIDTH)
    ) u_select (
        .i_req       (i__req),
        .i_ptr       (w_sel_ptr),
        .o_found     (w_found),
        .o_winner    (w_winner),
        .o_winner_id (w_winner_id)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;
        w_beat_nxt     = r_beat_count;
        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_state_nxt    = ARB_BUSY;
                    w_grant_nxt    = w_winner;
                    w_grant_id_nxt = w_winner_id;
                end
            end
            ARB_BUSY: begin
                if (w_release) begin
                    w_ptr_nxt  = w_ptr_inc;
                    w_beat_nxt = '0;
                    if (w_found) begin
                        w_grant_nxt    = w_winner;
                        w_grant_id_nxt = w_winner_id;
                    end else begin
                        w_state_nxt    = ARB_IDLE;
                        w_grant_nxt    = '0;
                        w_grant_id_nxt = '0;
                    end
                end else if (w_accept) begin
                    w_beat_nxt = r_beat_count + BURST_WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ARB_IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_grant_id   <= '0;
            r_beat_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_ptr        <= w_ptr_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_id   <= w_grant_id_nxt;
            r_beat_count <= w_beat_nxt;
        end
    end

    assign o__grant      = r_grant;
    assign o__grant_id   = r_grant_id;
    assign o__beat_count = r_beat_count;

endmodule
